// File: rtl/seq_detector_param.sv
// Serial pattern detector with per-bit mask, overlap control and registered match flag.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param #(
    parameter int              WIDTH    = 8,
    parameter int              CNT_W    = 16,
    parameter logic [WIDTH-1:0] PAT_INIT = WIDTH'(8'hAB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             primed
);

    localparam int               FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(WIDTH);

    logic [WIDTH-1:0]  hist_q, hist_d, hist_n;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    logic              match_q, match_d;
    logic              hit;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        match_d = 1'b0;
        hit     = 1'b0;
        hist_n  = {hist_q[WIDTH-2:0], in_bit};
        fill_n  = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (load) begin
            // The bit presented alongside load is intentionally dropped.
            pat_d  = pattern_in;
            mask_d = mask_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hit     = (fill_n == FULL) && (((hist_n ^ pat_q) & mask_q) == '0);
            hist_d  = hist_n;
            fill_d  = (hit && !overlap_en) ? '0 : fill_n;
            match_d = hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_INIT;
            mask_q  <= '1;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            match_q <= match_d;
        end
    end

    assign match  = match_q;
    assign primed = (fill_q == FULL);

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (hit && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: an 8-bit and a 4-bit/2-bit-counter instance
// share one serial stream and are checked against a queue-of-bits reference model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0, in_bit = 1'b0, load = 1'b0, overlap_en = 1'b1, clear = 1'b0;
    logic [7:0] pattern_in8 = '0, mask_in8 = '0;
    logic [3:0] pattern_in4 = '0, mask_in4 = '0;
    logic        match8, primed8, match4, primed4;
    logic [15:0] count8;
    logic [1:0]  count4;

    always #5 clk = ~clk;

    seq_detector_param dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .load(load),
        .pattern_in(pattern_in8), .mask_in(mask_in8), .overlap_en(overlap_en), .clear(clear),
        .match(match8), .match_count(count8), .primed(primed8));

    seq_detector_param #(.WIDTH(4), .CNT_W(2), .PAT_INIT(4'hA)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .load(load),
        .pattern_in(pattern_in4), .mask_in(mask_in4), .overlap_en(overlap_en), .clear(clear),
        .match(match4), .match_count(count4), .primed(primed4));

    typedef struct packed {
        logic        m8;
        logic        p8;
        logic [15:0] c8;
        logic        m4;
        logic        p4;
        logic [1:0]  c4;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: the last W accepted bits, oldest first.
    bit          qs[2][$];
    logic [31:0] pat[2], msk[2];
    int          cnt[2], mt[2];
    int          wid[2]  = '{8, 4};
    int          cmax[2] = '{65535, 3};

    function automatic bit window_hits(input bit q[$], input logic [31:0] p, input logic [31:0] m,
                                       input int w);
        if (q.size() != w) return 1'b0;
        for (int i = 0; i < w; i++)
            if (m[w-1-i] && (q[i] != p[w-1-i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.m8 = mt[0][0];
        e.p8 = (qs[0].size() == 8);
        e.m4 = mt[1][0];
        e.p4 = (qs[1].size() == 4);
`ifdef SEQDET_COUNT_EN
        e.c8 = 16'(cnt[0]);
        e.c4 = 2'(cnt[1]);
`else
        e.c8 = '0;
        e.c4 = '0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            qs[k].delete();
            cnt[k] = 0;
            mt[k]  = 0;
        end
        pat[0] = 32'hAB; msk[0] = 32'hFF;
        pat[1] = 32'hA;  msk[1] = 32'hF;
    endtask

    task automatic cyc(input logic v, input logic b, input logic ov = 1'b1, input logic ld = 1'b0,
                       input logic [7:0] p8 = 8'h0, input logic [7:0] m8 = 8'h0,
                       input logic [3:0] p4 = 4'h0, input logic [3:0] m4 = 4'h0,
                       input logic cl = 1'b0);
        in_valid = v; in_bit = b; overlap_en = ov; load = ld; clear = cl;
        pattern_in8 = p8; mask_in8 = m8; pattern_in4 = p4; mask_in4 = m4;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0;
            if (cl) begin
                qs[k].delete();
                cnt[k] = 0;
            end else if (ld) begin
                pat[k] = (k == 0) ? {24'h0, p8} : {28'h0, p4};
                msk[k] = (k == 0) ? {24'h0, m8} : {28'h0, m4};
                qs[k].delete();
            end else if (v) begin
                qs[k].push_back(b);
                if (qs[k].size() > wid[k]) void'(qs[k].pop_front());
                if (window_hits(qs[k], pat[k], msk[k], wid[k])) begin
                    mt[k] = 1;
                    if (cnt[k] < cmax[k]) cnt[k]++;
                    if (!ov) qs[k].delete();
                end
            end
        end
        exp_q.push_back(snapshot());
        #1;
    endtask

    task automatic send(input logic [7:0] by, input int nbits, input logic ov);
        for (int i = 7; i > 7 - nbits; i--) cyc(1'b1, by[i], ov);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0; load = 1'b0; clear = 1'b0;
        #1;
        vectors++;
        if ({match8, primed8, count8, match4, primed4, count4} != '0) begin
            miscompares++;
            $display("FAIL async_reset: got m8=%b p8=%b c8=%0d m4=%b p4=%b c4=%0d, want all 0",
                     match8, primed8, count8, match4, primed4, count4);
        end
        model_reset();
        @(posedge clk);
        exp_q.push_back(snapshot());
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if ({match8, primed8, count8, match4, primed4, count4} != e) begin
                miscompares++;
                $display("FAIL vec%0d @%0t: got m8=%b p8=%b c8=%0d m4=%b p4=%b c4=%0d, want m8=%b p8=%b c8=%0d m4=%b p4=%b c4=%0d",
                         vectors, $time, match8, primed8, count8, match4, primed4, count4,
                         e.m8, e.p8, e.c8, e.m4, e.p4, e.c4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();

        // Reset pattern AB on dut8; same stream hits 1010 twice on dut4.
        send(8'hAB, 8, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        // dut4 pattern 1010: overlapping then non-overlapping on stream 1010101.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 8'hFF, 4'hA, 4'hF);
        send(8'hAA, 7, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hAB, 8'hFF, 4'hA, 4'hF);
        send(8'hAA, 7, 1'b0);

        // Masked compare: only the low nibble of dut8 matters.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h0B, 8'h0F, 4'hA, 4'hF);
        send(8'hFB, 8, 1'b0);
        send(8'h3B, 8, 1'b0);
        send(8'hFA, 8, 1'b0);

        // Partial sequence aborted by reset, then a full one.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 8'hFF, 4'hB, 4'hF);
        send(8'hAB, 7, 1'b1);
        do_reset();
        send(8'hAB, 8, 1'b1);

        // All-zero mask on dut4: counter saturates, then clear.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 8'hFF, 4'h0, 4'h0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b1);
        cyc(1'b0, 1'b0);

        // Valid gaps, and a load that swallows its coincident bit.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAB, 8'hFF, 4'hA, 4'hF);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] by;
            by = 8'hAB;
            cyc(1'b1, by[i], 1'b1);
            cyc(1'b0, ~by[i], 1'b1);
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hAB, 8'hFF, 4'hA, 4'hF);
        cyc(1'b0, 1'b0);

        // Randomized traffic with occasional load/clear/overlap changes and one reset.
        begin
            logic ov;
            ov = 1'b1;
            for (int n = 0; n < 600; n++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 4) ov = ~ov;
                if (n == 300) do_reset();
                else if (r < 6)
                    cyc(1'b1, 1'b0, ov, 1'b0, 8'h0, 8'h0, 4'h0, 4'h0, 1'b1);
                else if (r < 10)
                    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ov, 1'b1,
                        8'($urandom), 8'($urandom & $urandom), 4'($urandom), 4'($urandom));
                else
                    cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ov);
            end
        end
        cyc(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter WIDTH, default 8, pattern/history length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 16, match counter width in bits.
REQ-003 Parameter PAT_INIT, default 8'hAB (WIDTH bits), pattern register value after reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_bit is accepted on this cycle's rising edge.
REQ-007 in_bit  input  1  serial data bit, MSB of pattern first.
REQ-008 load  input  1  latch pattern_in and mask_in into internal registers.
REQ-009 pattern_in  input  WIDTH  new pattern.
REQ-010 mask_in  input  WIDTH  per-bit compare enable; 1 = compare, 0 = don't care.
REQ-011 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 clear  input  1  synchronous clear of history, fill count and match counter.
REQ-013 match  output  1  registered Moore detect flag.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 primed  output  1  history holds WIDTH valid bits (fill == WIDTH).

Function
REQ-016 On an accepted bit, the history shall update to {hist[WIDTH-2:0], in_bit}.
REQ-017 The fill counter shall increment per accepted bit and saturate at WIDTH.
REQ-018 hit = (fill_next == WIDTH) && (((hist_next ^ pat_reg) & mask_reg) == 0), evaluated only on accepted bits.
REQ-019 match shall be 1 for exactly the one cycle following the edge that accepted the completing bit, and 0 in all other cycles, including cycles with in_valid low.
REQ-020 Overlap mode: after a hit, fill stays at WIDTH, so a hit is possible on the very next accepted bit.
REQ-021 Non-overlap mode: after a hit, fill shall reset to 0, so WIDTH new bits are required before the next hit.
REQ-022 mask_reg all-zero: every accepted bit with fill_next == WIDTH shall hit.
REQ-023 load shall latch pattern_in and mask_in and zero the history and fill; any bit presented in the same cycle shall be discarded and match shall be 0 next cycle.
REQ-024 clear shall zero the history, fill, match and match_count, and shall take priority over load and in_valid in the same cycle; pat_reg and mask_reg are unchanged.
REQ-025 A change of overlap_en shall take effect from the next accepted bit and shall not alter the stored history.

Reset
REQ-026 rst high shall immediately set: history = 0, fill = 0, match = 0, primed = 0, match_count = 0, pat_reg = PAT_INIT, mask_reg = all ones.
REQ-027 Reset asserted mid-sequence shall discard partial history; detection shall restart from an empty history after release.
REQ-028 The first rising edge after rst deasserts shall be a normal functional edge.

Configuration
REQ-029 Macro SEQDET_COUNT_EN defined: match_count shall increment by 1 per hit and saturate at 2^CNT_W-1 (no wrap).
REQ-030 SEQDET_COUNT_EN undefined: match_count shall be constant 0 and no counter flops shall be instantiated; all other behaviour is unchanged.

Verification
REQ-031 WIDTH=8, reset pattern 8'hAB, mask FF, bits 1,0,1,0,1,0,1,1 on consecutive valid cycles -> match=1 one cycle after 8th bit, only that cycle; match_count=1.
REQ-032 WIDTH=4, load pattern 4'b1010, overlap_en=1, stream 1010101 -> exactly 2 match pulses (after bits 4 and 6); overlap_en=0, same stream -> 1 pulse (after bit 4).
REQ-033 WIDTH=8, mask 8'h0F, pattern 8'h0B, stream 8'hFB then 8'h3B -> match after each byte; stream 8'hFA -> no match.
REQ-034 7 bits of 8'hAB, then rst pulse, then full 8'hAB -> no match before the reset; one match after the 8th post-reset bit.
REQ-035 CNT_W=2, SEQDET_COUNT_EN defined, 5 overlapping hits -> match_count sticks at 3; clear -> 0 next cycle; macro undefined -> match_count stays 0 throughout.
REQ-036 Bits interleaved with in_valid=0 gaps, plus load asserted with in_valid=1 -> gaps do not affect detection; the bit presented with load is discarded and primed=0 after the load.
